// File: rtl/regfile_mp_sb.sv
// Multi-port register file with a per-register busy scoreboard for issue/writeback.
// Define REGFILE_MP_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp_sb #(
  parameter int DATA_W        = 32,
  parameter int REG_W         = 5,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 2,
  parameter int HARDWIRE_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*REG_W-1:0]  rsel,
  output logic [NUM_RD*DATA_W-1:0] rdat,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*REG_W-1:0]  wsel,
  input  logic [NUM_WR*DATA_W-1:0] wdat,
  input  logic                     rsv_en,
  input  logic [REG_W-1:0]         rsv_sel,
  output logic                     rsv_ok,
  input  logic                     flush,
  output logic [2**REG_W-1:0]      busy_vec
);

  localparam int DEPTH = 2**REG_W;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic [REG_W-1:0]  wsel_a [NUM_WR];
  logic [DATA_W-1:0] wdat_a [NUM_WR];

  function automatic logic is_zero(input logic [REG_W-1:0] s);
    return (HARDWIRE_ZERO != 0) && (s == '0);
  endfunction

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
    assign wsel_a[j] = wsel[j*REG_W +: REG_W];
    assign wdat_a[j] = wdat[j*DATA_W +: DATA_W];
  end

  // Acceptance always looks at the registered scoreboard, never at same-cycle writes.
  assign rsv_ok   = rsv_en & ~flush & ~rst & ~busy_q[rsv_sel];
  assign busy_vec = busy_q;

  always_comb begin
    rf_d = rf_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wen[j] && !is_zero(wsel_a[j])) begin
        rf_d[wsel_a[j]] = wdat_a[j];
      end
    end
  end

  // Order matters: writeback clears, then an accepted reservation sets, then flush wipes all.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wen[j]) begin
        busy_d[wsel_a[j]] = 1'b0;
      end
    end
    if (rsv_ok && !is_zero(rsv_sel)) begin
      busy_d[rsv_sel] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    if (HARDWIRE_ZERO != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        rf_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [REG_W-1:0]  rs;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign rs = rsel[i*REG_W +: REG_W];

    always_comb begin
      rd = is_zero(rs) ? '0 : rf_q[rs];
      rb = is_zero(rs) ? 1'b0 : busy_q[rs];
`ifdef REGFILE_MP_SB_BYPASS_EN
      if (!rst) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wen[j] && (wsel_a[j] == rs) && !is_zero(rs)) begin
            rd = wdat_a[j];
            rb = 1'b0;
          end
        end
      end
`endif
    end

    assign rdat[i*DATA_W +: DATA_W] = rd;
    assign rbusy[i]                 = rb;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: driver pushes model predictions, monitor compares at negedge.
module tb_regfile_mp_sb;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int DEPTH  = 32;
  localparam int EW     = NUM_RD*DATA_W + NUM_RD + 1 + DEPTH;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*REG_W-1:0]  rsel;
  logic [NUM_RD*DATA_W-1:0] rdat;
  logic [NUM_RD-1:0]        rbusy;
  logic [NUM_WR-1:0]        wen;
  logic [NUM_WR*REG_W-1:0]  wsel;
  logic [NUM_WR*DATA_W-1:0] wdat;
  logic                     rsv_en;
  logic [REG_W-1:0]         rsv_sel;
  logic                     rsv_ok;
  logic                     flush;
  logic [DEPTH-1:0]         busy_vec;

  regfile_mp_sb #(
    .DATA_W(DATA_W), .REG_W(REG_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .HARDWIRE_ZERO(1)
  ) dut (
    .clk(clk), .rst(rst), .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
    .wen(wen), .wsel(wsel), .wdat(wdat), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .rsv_ok(rsv_ok), .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays updated by the architectural rules.
  logic [DATA_W-1:0] m_rf [DEPTH];
  bit                m_busy [DEPTH];
  logic [EW-1:0]     exp_q [$];
  int                n_vec = 0;
  int                n_err = 0;

  function automatic void model_clear();
    for (int k = 0; k < DEPTH; k++) begin
      m_rf[k]   = '0;
      m_busy[k] = 1'b0;
    end
  endfunction

  function automatic logic model_ok();
    return rsv_en && !flush && !rst && !m_busy[rsv_sel];
  endfunction

  function automatic logic [EW-1:0] model_out();
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rb;
    logic [DEPTH-1:0]         bv;
    int                       s;
    rd = '0;
    rb = '0;
    for (int k = 0; k < DEPTH; k++) bv[k] = m_busy[k];
    if (!rst) begin
      for (int i = 0; i < NUM_RD; i++) begin
        s = int'(rsel[i*REG_W +: REG_W]);
        rd[i*DATA_W +: DATA_W] = (s == 0) ? '0 : m_rf[s];
        rb[i] = (s == 0) ? 1'b0 : m_busy[s];
`ifdef REGFILE_MP_SB_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (wen[j] && int'(wsel[j*REG_W +: REG_W]) == s && s != 0) begin
            rd[i*DATA_W +: DATA_W] = wdat[j*DATA_W +: DATA_W];
            rb[i] = 1'b0;
          end
        end
`endif
      end
    end
    return {rd, rb, model_ok(), bv};
  endfunction

  function automatic void model_update();
    logic ok;
    int   ws;
    if (rst) begin
      model_clear();
      return;
    end
    ok = model_ok();
    for (int j = 0; j < NUM_WR; j++) begin
      ws = int'(wsel[j*REG_W +: REG_W]);
      if (wen[j] && ws != 0) begin
        m_rf[ws]   = wdat[j*DATA_W +: DATA_W];
        m_busy[ws] = 1'b0;
      end
    end
    if (ok && rsv_sel != 0) m_busy[rsv_sel] = 1'b1;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) m_busy[k] = 1'b0;
    end
  endfunction

  task automatic idle();
    rsel = '0; wen = '0; wsel = '0; wdat = '0;
    rsv_en = 1'b0; rsv_sel = '0; flush = 1'b0;
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic step();
    if (rst) model_clear();
    exp_q.push_back(model_out());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic expect_now(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {rdat, rbusy, rsv_ok, busy_vec};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL scoreboard at %0t: rdat=%h rbusy=%b rsv_ok=%b busy_vec=%h expected rdat=%h rbusy=%b rsv_ok=%b busy_vec=%h",
                 $time, a[EW-1 -: NUM_RD*DATA_W], a[DEPTH+1 +: NUM_RD], a[DEPTH], a[DEPTH-1:0],
                 e[EW-1 -: NUM_RD*DATA_W], e[DEPTH+1 +: NUM_RD], e[DEPTH], e[DEPTH-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset holds outputs at zero, even with a reservation request present.
    rsv_en = 1'b1; rsv_sel = 5'd3;
    #1 expect_now("rsv_ok_in_reset", {63'd0, rsv_ok}, 64'd0);
    step();
    step();
    rst = 1'b0;
    idle();
    rsel = {5'd7, 5'd3};
    #1 expect_now("rdat_after_reset", {rdat}, 64'd0);
    step();

    // Reserve then write back.
    rsv_en = 1'b1; rsv_sel = 5'd5;
    #1 expect_now("rsv5_ok", {63'd0, rsv_ok}, 64'd1);
    step();
    idle(); rsel = {5'd0, 5'd5};
    #1 expect_now("busy5_set", {62'd0, busy_vec[5], rbusy[0]}, 64'd3);
    step();
    wen = 2'b01; wsel = {5'd0, 5'd5}; wdat = {32'd0, 32'hDEADBEEF};
    step();
    idle(); rsel = {5'd0, 5'd5};
    #1 expect_now("wb5_data", {32'd0, rdat[31:0]}, 64'hDEADBEEF);
    expect_now("wb5_busy_clear", {63'd0, busy_vec[5]}, 64'd0);
    step();

    // WAW stall on register 9, cleared by a same-cycle writeback, then retried.
    rsv_en = 1'b1; rsv_sel = 5'd9;
    step();
    wen = 2'b10; wsel = {5'd9, 5'd0}; wdat = {32'h0000_0909, 32'd0};
    #1 expect_now("waw9_reject", {63'd0, rsv_ok}, 64'd0);
    step();
    idle(); rsv_en = 1'b1; rsv_sel = 5'd9;
    #1 expect_now("waw9_retry", {62'd0, busy_vec[9], rsv_ok}, 64'd1);
    step();

    // Two ports to one register: the higher port wins; register 0 stays 0.
    idle(); wen = 2'b11; wsel = {5'd4, 5'd4}; wdat = {32'h22, 32'h11};
    step();
    idle(); rsel = {5'd0, 5'd4};
    #1 expect_now("conflict4", {32'd0, rdat[31:0]}, 64'h22);
    step();
    wen = 2'b01; wsel = {5'd0, 5'd0}; wdat = {32'd0, 32'h55};
    step();
    idle(); rsel = {5'd0, 5'd0};
    #1 expect_now("zero_reg", {rdat}, 64'd0);
    step();

    // Flush with a pending reservation.
    foreach (m_rf[k]) if (0) ;
    rsv_en = 1'b1; rsv_sel = 5'd2; step();
    rsv_sel = 5'd3; step();
    rsv_sel = 5'd6; step();
    rsv_sel = 5'd8; flush = 1'b1;
    #1 expect_now("flush_reject", {63'd0, rsv_ok}, 64'd0);
    step();
    idle(); rsel = {5'd4, 5'd5};
    #1 expect_now("flush_busy_vec", {32'd0, busy_vec}, 64'd0);
    expect_now("flush_data_kept", {rdat}, {32'h22, 32'hDEADBEEF});
    step();

    // Same-cycle write/read of register 12.
    wen = 2'b01; wsel = {5'd0, 5'd12}; wdat = {32'd0, 32'h1234};
    step();
    idle(); rsel = {5'd0, 5'd12}; wen = 2'b01; wsel = {5'd0, 5'd12}; wdat = {32'd0, 32'hA5A5A5A5};
`ifdef REGFILE_MP_SB_BYPASS_EN
    #1 expect_now("bypass12", {32'd0, rdat[31:0]}, 64'hA5A5A5A5);
`else
    #1 expect_now("nobypass12", {32'd0, rdat[31:0]}, 64'h1234);
`endif
    step();
    idle(); rsel = {5'd0, 5'd12};
    #1 expect_now("after12", {32'd0, rdat[31:0]}, 64'hA5A5A5A5);
    step();

    // Randomised traffic with narrow index ranges to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      rsel    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      wen     = 2'($urandom_range(0, 3));
      wsel    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      wdat    = {$urandom, $urandom};
      rsv_en  = ($urandom_range(0, 2) != 0);
      rsv_sel = 5'($urandom_range(0, 15));
      flush   = ($urandom_range(0, 29) == 0);
      step();
    end
    rst = 1'b0;
    idle();

    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with a per-register scoreboard (busy bits) for the pipelined core.
- Successor to the single-write, dual-read register file: configurable width, depth, read-port count and write-port count.
- Adds destination reservation at issue, busy clear on writeback, flush, and optional write-to-read bypass.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits.
- REG_W, 5, register index width; depth = 2**REG_W.
- NUM_RD, 2, read port count (>=1).
- NUM_WR, 2, write port count (>=1).
- HARDWIRE_ZERO, 1, 1 = register 0 always reads 0, is never written and is never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rsel  in  NUM_RD*REG_W  read selects; port i uses slice i.
- rdat  out  NUM_RD*DATA_W  read data per port.
- rbusy  out  NUM_RD  busy bit of the selected register, per port.
- wen  in  NUM_WR  write enables.
- wsel  in  NUM_WR*REG_W  write selects.
- wdat  in  NUM_WR*DATA_W  write data.
- rsv_en  in  1  reserve a destination register (issue).
- rsv_sel  in  REG_W  register to reserve.
- rsv_ok  out  1  reservation accepted this cycle.
- flush  in  1  clear all busy bits.
- busy_vec  out  2**REG_W  full scoreboard state.

Behaviour:
- Reset (rst=1, asynchronous): all registers = 0 and all busy bits = 0. Consequently rdat = 0, rbusy = 0, busy_vec = 0 and rsv_ok = 0. Reset held mid-operation discards any pending writes or reservations.
- Write: on the rising edge, for each port j with wen[j]=1, rf[wsel_j] <= wdat_j and busy[wsel_j] <= 0.
  - Two or more ports targeting the same register in one cycle: the highest-index port wins the data.
  - HARDWIRE_ZERO=1: writes to register 0 are dropped.
- Read: combinational, rdat_i = rf[rsel_i]. Without bypass, a write becomes visible the cycle after wen. HARDWIRE_ZERO=1 with rsel_i=0 gives rdat_i = 0 and rbusy_i = 0.
- Reservation:
  - rsv_ok = rsv_en & ~flush & ~busy[rsv_sel] (combinational).
  - If rsv_ok: busy[rsv_sel] <= 1 at the edge.
  - If rsv_en and the target is already busy (WAW hazard): rsv_ok = 0 and no state change; the issuer stalls and retries.
  - rsv_sel = 0 with HARDWIRE_ZERO=1: rsv_ok = rsv_en & ~flush, and busy stays 0.
- Simultaneous reserve and write to the same register: the reservation check uses current busy state, so an already-busy target is rejected. If the target is not busy and is accepted, set beats clear and busy = 1 after the edge.
- Flush: all busy bits <= 0 at the edge; any rsv_en in that cycle is rejected (rsv_ok = 0). Writes in the flush cycle still update register data.
- busy_vec is the registered scoreboard, bit k = busy[k]; bit 0 is always 0 when HARDWIRE_ZERO=1.
- No other latency: all outputs are combinational functions of state and current inputs.

Optional Feature:
- Macro: REGFILE_MP_SB_BYPASS_EN.
- Defined:
  - If any wen[j]=1 with wsel_j = rsel_i (excluding register 0 when HARDWIRE_ZERO=1), rdat_i = wdat of the highest such j in the same cycle, and rbusy_i = 0.
  - rsv_ok is unchanged and still uses registered busy state.
- Undefined: reads return stored state only; same-cycle write data is visible the next cycle.

Test Plan:
- Reset then read: assert rst, release, set rsel = {3,7} -> rdat = {0,0}, rbusy = 0, busy_vec = 0.
- Reserve then write back: rsv_en, rsv_sel=5 -> rsv_ok=1; next cycle busy_vec[5]=1 and rbusy=1 when rsel=5. Then wen[0], wsel=5, wdat=0xDEADBEEF -> next cycle rdat=0xDEADBEEF, busy_vec[5]=0.
- WAW stall: register 9 busy, rsv_en rsv_sel=9 -> rsv_ok=0, busy_vec unchanged. Same cycle, wen[1] to register 9 -> next cycle busy 0; retry -> rsv_ok=1.
- Port conflict: wen=2'b11, both wsel=4, wdat0=0x11, wdat1=0x22 -> register 4 reads 0x22. Write 0x55 to register 0 -> reads 0 (HARDWIRE_ZERO=1).
- Flush: registers 2, 3, 6 busy, flush=1 with rsv_en rsv_sel=8 -> rsv_ok=0; next cycle busy_vec=0 with data intact.
- Bypass (macro defined): wen[0], wsel=12, wdat=0xA5A5A5A5, rsel0=12 same cycle -> rdat0=0xA5A5A5A5, rbusy0=0. With macro undefined -> old value that cycle, new value next cycle.
